// File: rtl/chroma_pred_pkg.sv
// Shared types and constants for the chroma 8x8 intra mode controller.
package chroma_pred_pkg;

    localparam int PIX_W     = 8;
    localparam int SAD_W     = 15;
    localparam int ROW_SAD_W = 11;

    typedef enum logic [1:0] {
        MODE_DC = 2'd0,
        MODE_H  = 2'd1,
        MODE_V  = 2'd2
    } chroma_mode_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_CB,
        S_SAD_CB,
        S_LOAD_CR,
        S_SAD_CR,
        S_DECIDE,
        S_DONE
    } ctrl_state_t;

    function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                  input logic [PIX_W-1:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/sad_row8.sv
// Combinational sum of absolute differences over one 8-pixel row.
module sad_row8
    import chroma_pred_pkg::*;
(
    input  logic [8*PIX_W-1:0]   orig,
    input  logic [8*PIX_W-1:0]   pred,
    output logic [ROW_SAD_W-1:0] sad
);

    always_comb begin
        sad = '0;
        for (int c = 0; c < 8; c++) begin
            sad = sad + ROW_SAD_W'(abs_diff(orig[c*PIX_W +: PIX_W], pred[c*PIX_W +: PIX_W]));
        end
    end

endmodule

// File: rtl/chroma_mode_ctrl.sv
// Sequences Cb then Cr chroma 8x8 prediction, accumulates V/H/DC SADs over
// both components and picks the MB chroma prediction mode.
//
// state     | meaning
// ----------+----------------------------------------------
// S_IDLE    | waiting for start
// S_LOAD_CB | pulse pred_enable with latched Cb neighbours
// S_SAD_CB  | consume 8 original Cb rows, accumulate SADs
// S_LOAD_CR | pulse pred_enable with latched Cr neighbours
// S_SAD_CR  | consume 8 original Cr rows, accumulate SADs
// S_DECIDE  | register the minimum-SAD mode
// S_DONE    | one-cycle done pulse
module chroma_mode_ctrl #(
    parameter int PIX_W = chroma_pred_pkg::PIX_W,
    parameter int SAD_W = chroma_pred_pkg::SAD_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [8*PIX_W-1:0]  cb_top,
    input  logic [8*PIX_W-1:0]  cb_left,
    input  logic [8*PIX_W-1:0]  cr_top,
    input  logic [8*PIX_W-1:0]  cr_left,
    input  logic [8*PIX_W-1:0]  orig_row,
    input  logic                orig_valid,
    output logic                orig_ready,
    output logic                pred_enable,
    output logic [8*PIX_W-1:0]  pred_top,
    output logic [8*PIX_W-1:0]  pred_left,
    input  logic [64*PIX_W-1:0] vpred,
    input  logic [64*PIX_W-1:0] hpred,
    input  logic [64*PIX_W-1:0] dcpred,
    output logic                busy,
    output logic                done,
    output logic [1:0]          best_mode,
    output logic [SAD_W-1:0]    best_sad
);

    import chroma_pred_pkg::*;

    localparam int ROW_BITS = 8 * PIX_W;

    ctrl_state_t state, state_nxt;
    logic        sel_cr;
    logic        accept;

    logic [2:0]          row_cnt;
    logic [SAD_W-1:0]    acc_v, acc_h, acc_dc;
    logic [ROW_BITS-1:0] cb_top_q, cb_left_q, cr_top_q, cr_left_q;

    logic [ROW_BITS-1:0]  v_row, h_row, dc_row;
    logic [ROW_SAD_W-1:0] row_sad_v, row_sad_h, row_sad_dc;

    chroma_mode_t     best_mode_q, cand_mode;
    logic [SAD_W-1:0] cand_sad;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        busy        = 1'b0;
        done        = 1'b0;
        pred_enable = 1'b0;
        orig_ready  = 1'b0;
        sel_cr      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_LOAD_CB;
            end
            S_LOAD_CB: begin
                busy        = 1'b1;
                pred_enable = 1'b1;
                state_nxt   = S_SAD_CB;
            end
            S_SAD_CB: begin
                busy       = 1'b1;
                orig_ready = 1'b1;
                if (orig_valid && row_cnt == 3'd7) state_nxt = S_LOAD_CR;
            end
            S_LOAD_CR: begin
                busy        = 1'b1;
                pred_enable = 1'b1;
                sel_cr      = 1'b1;
                state_nxt   = S_SAD_CR;
            end
            S_SAD_CR: begin
                busy       = 1'b1;
                orig_ready = 1'b1;
                sel_cr     = 1'b1;
                if (orig_valid && row_cnt == 3'd7) state_nxt = S_DECIDE;
            end
            S_DECIDE: begin
                busy      = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign accept    = orig_ready && orig_valid;
    assign pred_top  = sel_cr ? cr_top_q  : cb_top_q;
    assign pred_left = sel_cr ? cr_left_q : cb_left_q;

    // Predictor planes are row-major: pixel (r,c) sits at index 8r+c.
    assign v_row  = vpred [row_cnt*ROW_BITS +: ROW_BITS];
    assign h_row  = hpred [row_cnt*ROW_BITS +: ROW_BITS];
    assign dc_row = dcpred[row_cnt*ROW_BITS +: ROW_BITS];

    sad_row8 u_sad_v  (.orig(orig_row), .pred(v_row),  .sad(row_sad_v));
    sad_row8 u_sad_h  (.orig(orig_row), .pred(h_row),  .sad(row_sad_h));
    sad_row8 u_sad_dc (.orig(orig_row), .pred(dc_row), .sad(row_sad_dc));

    // DC wins ties, then H; V only when strictly smaller than both.
    always_comb begin
        cand_mode = MODE_DC;
        cand_sad  = acc_dc;
        if (acc_h < cand_sad) begin
            cand_mode = MODE_H;
            cand_sad  = acc_h;
        end
        if (acc_v < cand_sad) begin
            cand_mode = MODE_V;
            cand_sad  = acc_v;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row_cnt     <= '0;
            acc_v       <= '0;
            acc_h       <= '0;
            acc_dc      <= '0;
            cb_top_q    <= '0;
            cb_left_q   <= '0;
            cr_top_q    <= '0;
            cr_left_q   <= '0;
            best_mode_q <= MODE_DC;
            best_sad    <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                cb_top_q  <= cb_top;
                cb_left_q <= cb_left;
                cr_top_q  <= cr_top;
                cr_left_q <= cr_left;
                acc_v     <= '0;
                acc_h     <= '0;
                acc_dc    <= '0;
                row_cnt   <= '0;
            end
            if (accept) begin
                acc_v   <= acc_v  + SAD_W'(row_sad_v);
                acc_h   <= acc_h  + SAD_W'(row_sad_h);
                acc_dc  <= acc_dc + SAD_W'(row_sad_dc);
                row_cnt <= row_cnt + 3'd1;
            end
            if (state == S_DECIDE) begin
                best_mode_q <= cand_mode;
                best_sad    <= cand_sad;
            end
        end
    end

    assign best_mode = best_mode_q;

endmodule

// File: tb/tb_chroma_mode_ctrl.sv
// Scoreboard bench for chroma_mode_ctrl with a behavioural predictor and
// reference SAD/mode model.
module tb_chroma_mode_ctrl;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [63:0]  cb_top, cb_left, cr_top, cr_left, orig_row;
    logic         orig_valid;
    logic         orig_ready, pred_enable, busy, done;
    logic [63:0]  pred_top, pred_left;
    logic [511:0] vpred = '0, hpred = '0, dcpred = '0;
    logic [1:0]   best_mode;
    logic [14:0]  best_sad;

    chroma_mode_ctrl dut (
        .clk(clk), .reset(reset), .start(start),
        .cb_top(cb_top), .cb_left(cb_left), .cr_top(cr_top), .cr_left(cr_left),
        .orig_row(orig_row), .orig_valid(orig_valid), .orig_ready(orig_ready),
        .pred_enable(pred_enable), .pred_top(pred_top), .pred_left(pred_left),
        .vpred(vpred), .hpred(hpred), .dcpred(dcpred),
        .busy(busy), .done(done), .best_mode(best_mode), .best_sad(best_sad)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int mode;
        int sad;
        int start_cyc;
        int latency;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          done_seen = 0;
    int          pe_cnt   = 0;
    int          start_cyc = 0;

    logic [63:0] nb_top[2], nb_left[2];
    logic [63:0] orig_rows[16];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    function automatic int dc_of(input logic [63:0] top, input logic [63:0] left);
        int s = 8;
        for (int i = 0; i < 8; i++) s += int'(top[i*8 +: 8]) + int'(left[i*8 +: 8]);
        return s >>> 4;
    endfunction

    // Bench-owned predictor: V copies top, H copies left, DC is the rounded mean.
    always @(posedge clk) begin
        if (pred_enable) begin
            for (int r = 0; r < 8; r++) begin
                for (int c = 0; c < 8; c++) begin
                    vpred [(8*r+c)*8 +: 8] <= pred_top[c*8 +: 8];
                    hpred [(8*r+c)*8 +: 8] <= pred_left[r*8 +: 8];
                    dcpred[(8*r+c)*8 +: 8] <= 8'(dc_of(pred_top, pred_left));
                end
            end
        end
    end

    // Reference: total SAD per mode over both components, lowest wins, DC>H>V on ties.
    task automatic model(output int m, output int best);
        int sv = 0, sh = 0, sd = 0, dc, o;
        for (int k = 0; k < 2; k++) begin
            dc = dc_of(nb_top[k], nb_left[k]);
            for (int r = 0; r < 8; r++) begin
                for (int c = 0; c < 8; c++) begin
                    o = int'(orig_rows[k*8+r][c*8 +: 8]);
                    sv += iabs(o - int'(nb_top[k][c*8 +: 8]));
                    sh += iabs(o - int'(nb_left[k][r*8 +: 8]));
                    sd += iabs(o - dc);
                end
            end
        end
        m = 0; best = sd;
        if (sh < best) begin m = 1; best = sh; end
        if (sv < best) begin m = 2; best = sv; end
    endtask

    // Monitor: checks predictor hand-off and pops the scoreboard on done.
    always @(negedge clk) begin
        exp_t e;
        int   k;
        if (pred_enable) begin
            k = (pe_cnt == 0) ? 0 : 1;
            check("pred_top", longint'(pred_top), longint'(nb_top[k]));
            check("pred_left", longint'(pred_left), longint'(nb_left[k]));
            check("busy_in_load", longint'(busy), 1);
            pe_cnt++;
        end
        if (done) begin
            done_seen++;
            check("busy_low_at_done", longint'(busy), 0);
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("best_mode", longint'(best_mode), e.mode);
                check("best_sad", longint'(best_sad), e.sad);
                check("done_latency", cyc - e.start_cyc, e.latency);
            end
        end
    end

    task automatic run(input int sa_idx, input int sa_n, input int sb_idx, input int sb_n,
                       input int extra_at, input int abort_at);
        int  m, best, d0, t, idx, na, nb;
        bit  consumed, finished;
        exp_t e;
        cb_top = nb_top[0]; cb_left = nb_left[0];
        cr_top = nb_top[1]; cr_left = nb_left[1];
        model(m, best);
        pe_cnt = 0;
        d0 = done_seen;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        start_cyc = cyc - 1;
        // Scramble the live inputs: the controller must use its latched copy.
        cb_top = ~cb_top; cb_left = ~cb_left; cr_top = {$urandom, $urandom}; cr_left = ~cr_left;
        if (abort_at < 0) begin
            e.mode = m; e.sad = best; e.start_cyc = start_cyc; e.latency = 20 + sa_n + sb_n;
            exp_q.push_back(e);
        end
        check("busy_after_start", longint'(busy), 1);
        idx = 0; na = sa_n; nb = sb_n; finished = 0;
        for (int g = 0; g < 300 && !finished; g++) begin
            t = cyc - start_cyc;
            start = (t == extra_at);
            if (t == abort_at) begin
                exp_q.delete();
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0; start = 1'b0; orig_valid = 1'b0;
                check("abort_busy", longint'(busy), 0);
                check("abort_orig_ready", longint'(orig_ready), 0);
                check("abort_done", longint'(done), 0);
                check("abort_best_sad", longint'(best_sad), 0);
                repeat (25) @(posedge clk);
                #1;
                return;
            end
            consumed = 0;
            if (idx < 16) begin
                orig_row = orig_rows[idx];
                if (idx == sa_idx && na > 0) begin
                    na--; orig_valid = 1'b0;
                    check("ready_during_stall", longint'(orig_ready), 1);
                end else if (idx == sb_idx && nb > 0) begin
                    nb--; orig_valid = 1'b0;
                    check("ready_during_stall", longint'(orig_ready), 1);
                end else begin
                    orig_valid = 1'b1;
                end
                consumed = orig_valid && orig_ready;
            end else begin
                orig_valid = 1'b0;
            end
            @(posedge clk); #1;
            if (consumed) idx++;
            if (done_seen != d0) finished = 1;
        end
        start = 1'b0; orig_valid = 1'b0;
        if (!finished) check("done_timeout", 0, 1);
        else check("rows_consumed", idx, 16);
        repeat (25) @(posedge clk);
        #1;
        check("done_count", done_seen - d0, 1);
    endtask

    task automatic set_uniform(input int top_v, input int left_v, input int orig_v);
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) begin
                nb_top[k][i*8 +: 8]  = 8'(top_v);
                nb_left[k][i*8 +: 8] = 8'(left_v);
            end
        end
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 8; c++) orig_rows[r][c*8 +: 8] = 8'(orig_v);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; orig_valid = 1'b0; orig_row = '0;
        cb_top = '0; cb_left = '0; cr_top = '0; cr_left = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", longint'(busy), 0);
        check("rst_done", longint'(done), 0);
        check("rst_pred_enable", longint'(pred_enable), 0);
        check("rst_orig_ready", longint'(orig_ready), 0);
        check("rst_best_mode", longint'(best_mode), 0);
        check("rst_best_sad", longint'(best_sad), 0);
        check("rst_pred_top", longint'(pred_top), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // 1: flat 100 everywhere, DC wins the three-way tie at zero
        set_uniform(100, 100, 100);
        run(-1, 0, -1, 0, -1, -1);

        // 2: vertical ramp
        set_uniform(0, 0, 0);
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 8; i++) nb_top[k][i*8 +: 8] = 8'(10*i);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 8; c++) orig_rows[r][c*8 +: 8] = 8'(10*c);
        run(-1, 0, -1, 0, -1, -1);

        // 4: same data with stalls in both SAD phases
        run(4, 3, 12, 2, -1, -1);

        // 3: horizontal ramp
        set_uniform(200, 0, 0);
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 8; i++) nb_left[k][i*8 +: 8] = 8'(20*i);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 8; c++) orig_rows[r][c*8 +: 8] = 8'(20*(r % 8));
        run(-1, 0, -1, 0, -1, -1);

        // 5: maximum SAD plus an ignored start while busy
        set_uniform(0, 0, 255);
        run(-1, 0, -1, 0, 5, -1);

        // 6: reset mid-run, then a clean run
        set_uniform(100, 100, 100);
        run(-1, 0, -1, 0, -1, 6);
        run(-1, 0, -1, 0, -1, -1);

        // Start during DONE is ignored
        run(-1, 0, -1, 0, 20, -1);

        // Randomized neighbours, pixels and stalls
        for (int n = 0; n < 10; n++) begin
            int lo;
            lo = int'($urandom_range(0, 200));
            for (int k = 0; k < 2; k++) begin
                nb_top[k]  = {$urandom, $urandom};
                nb_left[k] = {$urandom, $urandom};
            end
            for (int r = 0; r < 16; r++)
                for (int c = 0; c < 8; c++)
                    orig_rows[r][c*8 +: 8] = 8'($urandom_range(lo, lo + 55));
            run(int'($urandom_range(1, 7)), int'($urandom_range(0, 3)),
                int'($urandom_range(9, 15)), int'($urandom_range(0, 3)), -1, -1);
        end

        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/chroma_mode_ctrl.md
Name: chroma_mode_ctrl

Overview:
- Sequences the chroma 8x8 intra predictor for one macroblock: Cb pass first, then Cr pass.
- Computes the SAD of the vertical, horizontal and DC predictions against the original pixels, accumulated over both components.
- Selects a single chroma prediction mode for the MB, as H.264 requires.
- Sits between the intra MB controller and the chroma 8x8 predictor.

Parameters:
- PIX_W, 8, pixel bit width
- SAD_W, 15, accumulator width; holds 128 px * 255 = 32640

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; samples all neighbour inputs
- cb_top  in  8x8  Cb top neighbours
- cb_left  in  8x8  Cb left neighbours
- cr_top  in  8x8  Cr top neighbours
- cr_left  in  8x8  Cr left neighbours
- orig_row  in  8x8  one row of original pixels
- orig_valid  in  1  orig_row valid
- orig_ready  out  1  controller consumes orig_row this cycle when valid
- pred_enable  out  1  enable to predictor
- pred_top  out  8x8  top pixels to predictor
- pred_left  out  8x8  left pixels to predictor
- vpred  in  64x8  predictor vertical output
- hpred  in  64x8  predictor horizontal output
- dcpred  in  64x8  predictor DC output
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse, results valid
- best_mode  out  2  0=DC, 1=H, 2=V (H.264 chroma numbering)
- best_sad  out  SAD_W  SAD of the chosen mode

Behaviour:
- Reset (synchronous, active-high): state IDLE. busy, done, pred_enable, orig_ready, best_mode, best_sad, all accumulators and the row counter = 0. Latched neighbours = 0.
- Reset mid-operation aborts immediately: no done pulse, accumulated results discarded.
- IDLE, start=1: latch all four neighbour arrays, clear the three accumulators, go to LOAD_CB.
- Start while busy is ignored.
- LOAD_CB (1 cycle): pred_top/pred_left = latched Cb arrays, pred_enable=1. Go to SAD_CB.
- SAD_CB: pred_enable=0 and pred_top/left held. Predictor outputs are valid from this cycle.
  - orig_ready=1.
  - On orig_valid: row r = row counter. Add to each accumulator the sum over c=0..7 of |orig_row[c] - pred[8r+c]| for that mode's plane.
  - Row SAD is 11 bits unsigned; use unsigned difference with no wrap.
  - orig_valid=0 stalls: no accumulate, counter holds.
  - After row 7 is consumed go to LOAD_CR; row counter wraps to 0.
- LOAD_CR / SAD_CR: identical to LOAD_CB / SAD_CB using the Cr arrays. After row 7 go to DECIDE.
- orig_ready=0 in all states except SAD_CB/SAD_CR.
- DECIDE (1 cycle): register the minimum of the three accumulators.
  - Tie priority: DC > H > V (strict less-than required to displace).
  - Go to DONE.
- DONE (1 cycle): done=1, busy=0. best_mode/best_sad hold until the next DECIDE. Go to IDLE.
- A start arriving during DONE is ignored.
- Latency with orig_valid held high: start sampled at edge 0.
  - LOAD_CB = cycle 1; SAD_CB = cycles 2-9.
  - LOAD_CR = cycle 10; SAD_CR = cycles 11-18.
  - DECIDE = cycle 19; done = cycle 20.
  - Each stall cycle adds 1.
- Accumulators never overflow at SAD_W=15.

Decomposition:
- Package chroma_pred_pkg:
  - chroma_mode_t enum (DC=0, H=1, V=2)
  - PIX_W, SAD_W, ROW_SAD_W=11
  - ctrl state enum
- Sub-module sad_row8: combinational. 8 original + 8 predicted pixels in, 11-bit SAD out. Instantiated three times (V, H, DC).

Test Plan:
1. All neighbours = 100, orig all 100, orig_valid held high -> all SADs 0; best_mode=0 (DC by tie), best_sad=0; done exactly 20 cycles after start.
2. top[i]=10*i, left=0 for Cb and Cr; every orig row = 0,10,...,70 -> best_mode=2 (V), best_sad=0.
3. top=200, left[i]=20*i for both; orig row r all = 20*r -> best_mode=1 (H), best_sad=0.
4. Scenario 2 with orig_valid low for 3 cycles during SAD_CB row 4 and 2 cycles in SAD_CR -> identical results; done at cycle 25; orig_ready=1 throughout stalls.
5. Neighbours 0, orig all 255 -> all accumulators 32640; best_mode=0, best_sad=32640 (no overflow). Second start pulsed at cycle 5 is ignored; exactly one done.
6. reset asserted at cycle 6 of a run -> next cycle busy=0, orig_ready=0, no done. New start then completes scenario 1 with done 20 cycles later.
